// File: rtl/hamming_serial_rx_pkg.sv
// Shared definitions for the Hamming serial receive path: codeword width,
// line levels of the async frame, and the receiver FSM state encoding.
// The matching serial transmitter uses the same constants.
package hamming_serial_rx_pkg;

  localparam int CW_BITS = 8;

  // Frame: 1 start bit, CW_BITS data bits LSB-first, 1 stop bit, idle high.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/hamming_rx_fifo.sv
// First-word-fall-through codeword buffer.
//   clk, rst_n  clock, async active-low reset
//   push        write push_data this cycle (accepted if not full, or if popping)
//   push_data   codeword to store
//   pop         consumer takes the head (ignored when empty)
//   head        current head codeword, 0 when empty
//   empty       no entries held
//   drop        push refused: full and no pop this cycle
//   count       entries held (one bit wider than the pointers)
module hamming_rx_fifo
  import hamming_serial_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CW_BITS-1:0]       push_data,
  input  logic                     pop,
  output logic [CW_BITS-1:0]       head,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign drop    = push && !push_ok;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; entries are only ever read behind
  // the count, so clearing them would just add reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are power-of-2 wide, so they wrap modulo DEPTH on their own.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial front end for the Hamming decode path. Deframes 8N1 codewords from an
// asynchronous single-wire line, buffers them, and hands them downstream over
// a valid/ready handshake.
//   clk, rst_n    clock, async active-low reset (released synchronously inside)
//   ser_in        serial line, idle high, asynchronous to clk
//   cw_data       FIFO head codeword (bit0 = first data bit received), 0 when empty
//   cw_valid      FIFO non-empty
//   cw_ready      consumer accepts; pop when cw_valid & cw_ready
//   fifo_count    entries held
//   frame_err     1-cycle pulse: stop bit sampled low, byte discarded
//   overflow      sticky: good byte dropped because the FIFO was full
//   clr_overflow  synchronous clear of overflow (a same-cycle set wins)
module hamming_serial_rx
  import hamming_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ser_in,
  output logic [CW_BITS-1:0]            cw_data,
  output logic                          cw_valid,
  input  logic                          cw_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                IDX_W     = $clog2(CW_BITS);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CW_BITS - 1);

  // Reset: asserts immediately, releases two clocks after rst_n rises.
  logic rst_meta, rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Line synchroniser plus one extra stage for falling-edge detection.
  logic s_meta, s_in, s_prev;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      s_meta <= IDLE_LEVEL;
      s_in   <= IDLE_LEVEL;
      s_prev <= IDLE_LEVEL;
    end else begin
      s_meta <= ser_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end

  rx_state_e          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CW_BITS-1:0] sr, sr_n;
  logic               bit_done;
  logic               push;
  logic               stop_bad;
  logic               drop;
  logic               empty;

  assign bit_done = (cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sr    <= sr_n;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sr_n    = sr;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        // Requires a true 1->0 edge, so a line held low after an error stays idle.
        if (s_prev == IDLE_LEVEL && s_in == START_LEVEL) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          // High at mid start bit means the falling edge was a glitch.
          state_n = (s_in == START_LEVEL) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          sr_n  = {s_in, sr[CW_BITS-1:1]};
          idx_n = idx + 1'b1;
          if (idx == IDX_LAST) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    push     = 1'b0;
    stop_bad = 1'b0;
    if (state == ST_STOP && bit_done) begin
      push     = (s_in == STOP_LEVEL);
      stop_bad = (s_in != STOP_LEVEL);
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  hamming_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_sync_n),
    .push      (push),
    .push_data (sr),
    .pop       (cw_ready),
    .head      (cw_data),
    .empty     (empty),
    .drop      (drop),
    .count     (fifo_count)
  );

  assign cw_valid = !empty;

endmodule
